// File: rtl/fewcore_scoreboard.sv
// Per-register write-back countdown scoreboard: RAW stall/forward decisions and WAW ordering stalls.
// Optional stall performance counter enabled by defining FEWCORE_SB_PERF_EN.
module fewcore_scoreboard #(
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MAX_LAT    = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic                  issue_use_rs1,
    input  logic                  issue_use_rs2,
    input  logic                  issue_wr,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [CNT_W-1:0]      issue_lat,
    input  logic                  sb_clear,
    output logic                  issue_ready,
    output logic                  fwd_rs1,
    output logic                  fwd_rs2,
    output logic                  busy,
    output logic [31:0]           stall_cycles
);

    // Register 0 is hardwired zero, so it has no counter.
    logic [CNT_W-1:0] cnt_q [1:REG_COUNT-1];
    logic [CNT_W-1:0] cnt_d [1:REG_COUNT-1];

    logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd;
    logic [CNT_W-1:0] lat_eff;
    logic             raw_rs1, raw_rs2, waw, accept;

    // Index 0 (and any index beyond REG_COUNT-1) reads back as "nothing pending".
    always_comb begin
        cnt_rs1 = '0;
        cnt_rs2 = '0;
        cnt_rd  = '0;
        for (int unsigned i = 1; i < REG_COUNT; i++) begin
            if (issue_rs1 == REG_ADDR_W'(i)) cnt_rs1 = cnt_q[i];
            if (issue_rs2 == REG_ADDR_W'(i)) cnt_rs2 = cnt_q[i];
            if (issue_rd == REG_ADDR_W'(i))  cnt_rd  = cnt_q[i];
        end
    end

    always_comb begin
        if (issue_lat == '0) begin
            lat_eff = CNT_W'(1);
        end else if (issue_lat > CNT_W'(MAX_LAT)) begin
            lat_eff = CNT_W'(MAX_LAT);
        end else begin
            lat_eff = issue_lat;
        end
    end

    always_comb begin
        raw_rs1     = issue_use_rs1 && (cnt_rs1 > CNT_W'(1));
        raw_rs2     = issue_use_rs2 && (cnt_rs2 > CNT_W'(1));
        fwd_rs1     = issue_use_rs1 && (cnt_rs1 == CNT_W'(1));
        fwd_rs2     = issue_use_rs2 && (cnt_rs2 == CNT_W'(1));
        waw         = issue_wr && (issue_rd != '0) && (cnt_rd >= lat_eff);
        issue_ready = issue_valid && !raw_rs1 && !raw_rs2 && !waw && !sb_clear && reset;
        accept      = issue_valid && issue_ready;
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 1; i < REG_COUNT; i++) begin
            busy = busy | (cnt_q[i] != '0);
            if (sb_clear) begin
                cnt_d[i] = '0;
            end else if (accept && issue_wr && (issue_rd == REG_ADDR_W'(i))) begin
                cnt_d[i] = lat_eff;
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 1; i < REG_COUNT; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 1; i < REG_COUNT; i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef FEWCORE_SB_PERF_EN
    logic [31:0] stall_q, stall_d;

    // Saturating; sb_clear deliberately leaves it alone.
    always_comb begin
        stall_d = stall_q;
        if (issue_valid && !issue_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_q <= '0;
        else        stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule
